bcd_to_bin_conv: RTL and testbench

- Sequential converter that turns a packed 3-digit BCD value (hundreds/tens/ones) into a 10-bit unsigned binary value.
- Uses reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more.
- It is the inverse of the timer's binary-to-BCD path, and lets BCD-entered presets (e.g. from switches or keypad) load binary counters.
- Runs in the 50 MHz domain with a start/busy/done handshake.

---
 rtl/bcd_to_bin_conv.sv | 145 ++++++++++++++
 tb/tb_bcd_to_bin_conv.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_conv.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// One result bit is recovered per clock; start/busy/done handshake.
module bcd_to_bin_conv #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_pend_q;
    logic [BIN_W-1:0]    bin_hold_q;
    logic                err_hold_q;
    logic [BIN_W-1:0]    result;

    function automatic logic any_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Shift right, then pull each BCD digit back from 8..15 by 3 (no inter-digit carry).
    function automatic logic [WORK_W-1:0] shift_adjust(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = w >> 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (s[BIN_W + 4*i +: 4] >= 4'd8) begin
                s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                // An invalid capture spends one busy cycle here without shifting.
                if (err_pend_q || (cnt_q == CNT_LAST)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            work_q     <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            bin_hold_q <= '0;
            err_hold_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        work_q     <= {bcd_in, {BIN_W{1'b0}}};
                        cnt_q      <= '0;
                        err_pend_q <= any_invalid(bcd_in);
                    end
                end
                StShift: begin
                    if (!err_pend_q) begin
                        work_q <= shift_adjust(work_q);
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    bin_hold_q <= result;
                    err_hold_q <= err_pend_q;
                end
                default: begin
                    work_q <= work_q;
                end
            endcase
        end
    end

    assign result = err_pend_q ? '0 : work_q[BIN_W-1:0];

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        bin_out = bin_hold_q;
        err     = err_hold_q;
        unique case (state_q)
            StShift: begin
                busy = 1'b1;
            end
            StDone: begin
                done    = 1'b1;
                bin_out = result;
                err     = err_pend_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Self-checking bench for bcd_to_bin_conv: directed cases plus a shuffled
// sweep of every valid 3-digit BCD input against a decimal reference model.
module tb_bcd_to_bin_conv;

    logic        clk_50MHz;
    logic        reset;
    logic        start;
    logic [11:0] bcd_in;
    logic [9:0]  bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;
    int done_cnt;

    bcd_to_bin_conv #(
        .DIGITS (3),
        .BIN_W  (10)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .bin_out   (bin_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    always @(negedge clk_50MHz) begin
        if (done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: plain decimal weighting of the digits.
    function automatic int ref_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic ref_invalid(input logic [11:0] b);
        return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] b;
        b[11:8] = 4'(v / 100);
        b[7:4]  = 4'((v / 10) % 10);
        b[3:0]  = 4'(v % 10);
        return b;
    endfunction

    // One start pulse, wait for done (bounded), check result, latency and hold.
    task automatic run_conv(input logic [11:0] bcd, input string tag);
        logic       inv;
        int         expv;
        int         lat;
        int         busy_cycles;
        int         dc0;
        inv  = ref_invalid(bcd);
        expv = inv ? 0 : ref_value(bcd);
        dc0  = done_cnt;
        @(negedge clk_50MHz);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk_50MHz);
        #1;
        start  = 1'b0;
        bcd_in = 12'($urandom);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk_50MHz);
            #1;
            lat++;
        end
        if (!done) begin
            check_eq({tag, "_timeout"}, 0, 1);
            return;
        end
        check_eq({tag, "_latency"}, lat, inv ? 1 : 10);
        if (!inv) check_eq({tag, "_busy_cycles"}, busy_cycles, 10);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        check_eq({tag, "_bin_out"}, bin_out, expv);
        check_eq({tag, "_err"}, err, inv);
        @(posedge clk_50MHz);
        #1;
        check_eq({tag, "_done_drop"}, done, 0);
        check_eq({tag, "_bin_hold"}, bin_out, expv);
        check_eq({tag, "_err_hold"}, err, inv);
        check_eq({tag, "_done_once"}, done_cnt - dc0, 1);
    endtask

    int vals [1000];
    int first_lat;
    int period;
    int dc_snap;

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        reset    = 1'b1;
        start    = 1'b0;
        bcd_in   = '0;
        repeat (2) @(posedge clk_50MHz);
        #1;
        check_eq("rst_bin_out", bin_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk_50MHz);
        reset = 1'b0;

        run_conv(12'h999, "c999");
        run_conv(12'h000, "c000");
        run_conv(12'h255, "c255");
        run_conv(12'h100, "c100");
        run_conv(12'h059, "c059");
        run_conv(12'h2A5, "c2A5");
        run_conv(12'h123, "c123");
        run_conv(12'hF00, "cF00");

        // Start held high: one done per conversion, 12-cycle done period.
        @(negedge clk_50MHz);
        bcd_in = 12'h471;
        start  = 1'b1;
        first_lat = 0;
        while (!done && first_lat < 40) begin
            @(posedge clk_50MHz);
            #1;
            first_lat++;
        end
        check_eq("held_first_done", done, 1);
        check_eq("held_first_val", bin_out, 471);
        @(posedge clk_50MHz);
        #1;
        check_eq("held_single_pulse", done, 0);
        period = 1;
        while (!done && period < 40) begin
            @(posedge clk_50MHz);
            #1;
            period++;
        end
        check_eq("held_period", period, 12);
        check_eq("held_second_val", bin_out, 471);
        @(negedge clk_50MHz);
        start = 1'b0;
        repeat (14) @(posedge clk_50MHz);

        // Reset at E5 of a 999 conversion aborts with no done pulse.
        @(negedge clk_50MHz);
        bcd_in = 12'h999;
        start  = 1'b1;
        @(posedge clk_50MHz);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk_50MHz);
        #1;
        check_eq("abort_busy_before", busy, 1);
        dc_snap = done_cnt;
        reset = 1'b1;
        #1;
        check_eq("abort_bin_out", bin_out, 0);
        check_eq("abort_err", err, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        reset = 1'b0;
        repeat (15) @(posedge clk_50MHz);
        check_eq("abort_no_done", done_cnt - dc_snap, 0);
        run_conv(12'h007, "c007");

        // Shuffled sweep of all valid inputs.
        for (int i = 0; i < 1000; i++) vals[i] = i;
        for (int i = 999; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        dc_snap = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            run_conv(to_bcd(vals[i]), "sweep");
        end
        check_eq("sweep_done_total", done_cnt - dc_snap, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
